// File: rtl/instruction_loader_pkg.sv
// Shared IF-stage header: loader parameter defaults, FSM encodings, HALT word
// and instruction memory geometry.
package instruction_loader_pkg;

    localparam int REG_SIZE_DEFAULT         = 32;
    localparam int BYTE_SIZE_DEFAULT        = 8;
    localparam int MAX_INSTRUCTIONS_DEFAULT = 64;

    localparam logic [31:0] INSTRUCTION_HALT = 32'hFFFF_FFFF;

    // Instruction memory holds exactly one loader image
    localparam int IMEM_DEPTH  = MAX_INSTRUCTIONS_DEFAULT;
    localparam int IMEM_ADDR_W = $clog2(IMEM_DEPTH);

    typedef logic [2:0] loader_state_t;

    localparam loader_state_t ST_IDLE    = 3'd0;
    localparam loader_state_t ST_RECEIVE = 3'd1;
    localparam loader_state_t ST_WRITE   = 3'd2;
    localparam loader_state_t ST_READY   = 3'd3;
    localparam loader_state_t ST_RUNNING = 3'd4;
    localparam loader_state_t ST_ERROR   = 3'd5;

    function automatic int byte_cnt_width(input int word_w, input int byte_w);
        int n;
        n = word_w / byte_w;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte-to-word shift register: first byte ends up in the MSBs,
// with a modulo byte counter and a word-complete flag.
module word_assembler
    import instruction_loader_pkg::*;
#(
    parameter int WORD_W = REG_SIZE_DEFAULT,
    parameter int BYTE_W = BYTE_SIZE_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] next_word_o,
    output logic              complete_o
);

    localparam int NBYTES = WORD_W / BYTE_W;
    localparam int CNT_W  = byte_cnt_width(WORD_W, BYTE_W);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    logic [WORD_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Word as it will look once the incoming byte is shifted in
    assign next_word_o = (word_q << BYTE_W) | WORD_W'(byte_i);
    assign complete_o  = shift_i && (cnt_q == LAST_BYTE);

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift_i) begin
            word_d = next_word_o;
            cnt_d  = (cnt_q == LAST_BYTE) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Loads a program byte-stream into instruction memory word by word until HALT,
// then waits for a run command and fires a single start strobe.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int REG_SIZE         = REG_SIZE_DEFAULT,
    parameter int BYTE_SIZE        = BYTE_SIZE_DEFAULT,
    parameter int MAX_INSTRUCTIONS = MAX_INSTRUCTIONS_DEFAULT
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic [BYTE_SIZE-1:0]                i_rx_data,
    input  logic                                i_rx_valid,
    input  logic                                i_load_enable,
    input  logic                                i_run,
    output logic [REG_SIZE-1:0]                 o_instruction,
    output logic                                o_instruction_write,
    output logic                                o_start,
    output logic                                o_loading,
    output logic                                o_ready,
    output logic                                o_error,
    output logic [$clog2(MAX_INSTRUCTIONS):0]   o_count
);

    localparam int COUNT_W = $clog2(MAX_INSTRUCTIONS) + 1;
    localparam logic [REG_SIZE-1:0] HALT_WORD = REG_SIZE'(INSTRUCTION_HALT);
    localparam logic [COUNT_W-1:0]  LAST_SLOT = COUNT_W'(MAX_INSTRUCTIONS - 1);

    loader_state_t        state_q, state_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [REG_SIZE-1:0]  instr_q, instr_d;
    logic                 write_q, start_q, loading_q, ready_q, error_q;

    logic                 asm_clear;
    logic                 asm_shift;
    logic                 asm_complete;
    logic [REG_SIZE-1:0]  asm_next_word;

    word_assembler #(
        .WORD_W (REG_SIZE),
        .BYTE_W (BYTE_SIZE)
    ) u_word_assembler (
        .clk_i       (i_clk),
        .rst_i       (i_reset),
        .clear_i     (asm_clear),
        .shift_i     (asm_shift),
        .byte_i      (i_rx_data),
        .next_word_o (asm_next_word),
        .complete_o  (asm_complete)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        instr_d   = instr_q;
        asm_clear = 1'b0;
        asm_shift = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_load_enable) begin
                    state_d   = ST_RECEIVE;
                    count_d   = '0;
                    asm_clear = 1'b1;
                end
            end

            ST_RECEIVE: begin
                asm_shift = i_rx_valid;
                if (asm_complete) begin
                    // Last free slot is reserved for HALT; anything else overflows
                    if ((count_q == LAST_SLOT) && (asm_next_word != HALT_WORD)) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_WRITE;
                        instr_d = asm_next_word;
                    end
                end
            end

            ST_WRITE: begin
                // Keep accepting bytes so the next word's first byte is not lost
                asm_shift = i_rx_valid;
                count_d   = count_q + COUNT_W'(1);
                state_d   = (instr_q == HALT_WORD) ? ST_READY : ST_RECEIVE;
            end

            ST_READY: begin
                if (i_run) begin
                    state_d = ST_RUNNING;
                end
            end

            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            instr_q   <= '0;
            write_q   <= 1'b0;
            start_q   <= 1'b0;
            loading_q <= 1'b0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            instr_q   <= instr_d;
            // Status flags are registered from the next state so they align with it
            write_q   <= (state_d == ST_WRITE);
            start_q   <= (state_q == ST_READY) && (state_d == ST_RUNNING);
            loading_q <= (state_d == ST_RECEIVE) || (state_d == ST_WRITE);
            ready_q   <= (state_d == ST_READY);
            error_q   <= (state_d == ST_ERROR);
        end
    end

    assign o_instruction       = instr_q;
    assign o_instruction_write = write_q;
    assign o_start             = start_q;
    assign o_loading           = loading_q;
    assign o_ready             = ready_q;
    assign o_error             = error_q;
    assign o_count             = count_q;

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The module SHALL expose the following parameters:
  - REG_SIZE, default 32, instruction word width.
  - BYTE_SIZE, default 8, receive byte width.
  - MAX_INSTRUCTIONS, default 64, capacity in words including HALT.
REQ-002 The module SHALL expose the following ports (clock and reset first):
  - i_clk  in  1  clock.
  - i_reset  in  1  reset, asynchronous, active-high.
  - i_rx_data  in  BYTE_SIZE  received byte.
  - i_rx_valid  in  1  one-cycle strobe, i_rx_data valid.
  - i_load_enable  in  1  begin-load command.
  - i_run  in  1  start-execution command.
  - o_instruction  out  REG_SIZE  assembled word, held until next word.
  - o_instruction_write  out  1  one-cycle write strobe to instruction memory.
  - o_start  out  1  one-cycle start strobe to instruction memory.
  - o_loading  out  1  high in RECEIVE/WRITE.
  - o_ready  out  1  high in READY.
  - o_error  out  1  sticky overflow flag.
  - o_count  out  $clog2(MAX_INSTRUCTIONS)+1  words written including HALT.

Function
REQ-003 The FSM SHALL have states IDLE, RECEIVE, WRITE, READY, RUNNING and ERROR.
REQ-004 IDLE: i_load_enable=1 SHALL transition to RECEIVE and clear o_count, the byte counter and the assembler; i_rx_valid SHALL be ignored.
REQ-005 RECEIVE: each i_rx_valid SHALL shift i_rx_data in, first byte becoming the MSB (big-endian), and increment the byte counter modulo REG_SIZE/BYTE_SIZE.
REQ-006 On the cycle the last byte of a word is accepted, the assembled word SHALL be registered to o_instruction and the FSM SHALL enter WRITE.
REQ-007 WRITE SHALL last exactly one cycle, with o_instruction_write=1 and o_instruction stable.
REQ-008 A byte strobed during WRITE SHALL be accepted as byte 0 of the next word, so no byte is lost.
REQ-009 After WRITE, o_count SHALL increment by 1:
  - next state READY if the word equals INSTRUCTION_HALT;
  - next state RECEIVE otherwise.
REQ-010 If the MAX_INSTRUCTIONS-th word is not HALT, it SHALL NOT be written (no strobe, o_count unchanged) and the FSM SHALL enter ERROR.
REQ-011 READY: o_ready=1; i_run=1 SHALL pulse o_start for one cycle and enter RUNNING; i_load_enable and i_rx_valid SHALL be ignored.
REQ-012 i_run and i_load_enable SHALL be ignored in every state other than those named in REQ-004 and REQ-011.
REQ-013 RUNNING and ERROR SHALL be terminal until reset; o_error=1 in ERROR only.
REQ-014 All outputs SHALL be registered: o_instruction_write, o_start and o_instruction change only on i_clk rising edges.
REQ-015 o_instruction_write and o_start SHALL never be asserted in the same cycle.

Reset
REQ-016 i_reset SHALL asynchronously force the following, from any state including mid-word:
  - state IDLE;
  - o_instruction 0;
  - o_instruction_write, o_start, o_loading, o_ready, o_error 0;
  - o_count 0;
  - byte counter and assembler 0.
REQ-017 A partially received word at reset SHALL be discarded, with no write strobe.

Structure
REQ-018 State encodings, INSTRUCTION_HALT (32'hFFFFFFFF) and the parameter defaults SHALL live in the shared IF-stage header alongside the instruction memory constants.
REQ-019 Byte-to-word assembly SHALL be a sub-module, word_assembler, providing shift, byte count, clear and word-complete flag.

Verification
REQ-020 Load: i_load_enable, then bytes 20 08 00 05, then FF FF FF FF:
  - one write strobe with 32'h20080005;
  - one write strobe with 32'hFFFFFFFF;
  - o_ready=1, o_count=2.
REQ-021 READY, then i_run pulse: o_start=1 for exactly one cycle, FSM in RUNNING; a later i_run or i_load_enable produces no strobes.
REQ-022 MAX_INSTRUCTIONS=4, four non-HALT words: three write strobes, o_error=1, o_count=3, fourth word not written.
REQ-023 Reset after 2 bytes, then a reloaded HALT: outputs 0 during reset; after reload, exactly one write strobe with 32'hFFFFFFFF.
REQ-024 Back-to-back: first byte of word 2 strobed in the WRITE cycle of word 1: word 2 assembles correctly (8C010004 then 00000000), no byte dropped.
REQ-025 i_rx_valid in IDLE and i_run in RECEIVE: no write strobe and no o_start.
